if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 16-bit pipelined processor: owns the PC, issues word requests to instruction memory over a req/ready handshake, and loads the IF/ID pipeline register (`instruction`, `PC`, `NextPC`) consumed by the decode stage. It acts on the decode stage's redirect outputs (branch, jump and register-target addresses plus kill) and on the hazard unit's stall. It inserts NOP bubbles (16'h0000) for memory wait states and squashed fetches, and counts fetched instructions and bubbles.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset
- `NOP`, 16'h0000, bubble word written to IF/ID (decode ignores 16'h0000)
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `stall` in 1: hazard unit; hold PC and IF/ID.
- `kill` in 1: decode resolved a taken redirect; squash and redirect.
- `PCSrc` in 2: redirect select, sampled only when kill=1. 00 = PC+1, 01 = Branch_TA, 10 = Jump_TA, 11 = For_TA.
- `Branch_TA`, `Jump_TA`, `For_TA` in 16: redirect targets from decode.
- `imem_req` out 1: request valid.
- `imem_addr` out 16: word address, stable while req=1 and ready=0.
- `imem_data` in 16: instruction word, valid in the cycle ready=1.
- `imem_ready` in 1: completes the current request.
- `instruction` out 16: IF/ID instruction.
- `PC` out 16: IF/ID address of `instruction`.
- `NextPC` out 16: IF/ID value of PC+1 (return address for RR).
- `num_fetched` out 16: count of instructions delivered to IF/ID.
- `num_bubbles` out 16: count of NOPs inserted.

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `addr_q`: address of the outstanding request; drives `imem_addr`.
  - `hold_buf`: 16-bit holding register.
  - `state`: FETCH, HOLD or DRAIN.
- Priority each cycle: reset > stall > kill > normal. kill is ignored while stall=1; decode cannot resolve a stalled branch.
- Redirect target `tgt` = mux of PC+1 / Branch_TA / Jump_TA / For_TA selected by PCSrc.
- Handshake: `imem_req`=1 in FETCH and DRAIN, 0 in HOLD and in reset. Once req is raised, `addr_q` is frozen until ready=1.
- FETCH:
  - stall=0, kill=0, ready=1: IF/ID ← {imem_data, addr_q, addr_q+1}; pc, addr_q ← addr_q+1; num_fetched+1.
  - stall=0, kill=0, ready=0: IF/ID ← {NOP, 0, 0}; num_bubbles+1; pc holds.
  - stall=1, ready=1: hold_buf ← imem_data → HOLD. IF/ID and pc hold.
  - stall=1, ready=0: everything holds.
  - kill=1, ready=1: response discarded; IF/ID ← NOP (bubble+1); pc, addr_q ← tgt.
  - kill=1, ready=0: IF/ID ← NOP (bubble+1); pc ← tgt; addr_q holds → DRAIN.
- HOLD:
  - stall=1: hold.
  - stall=0, kill=0: IF/ID ← {hold_buf, addr_q, addr_q+1}; pc, addr_q ← addr_q+1; fetched+1 → FETCH.
  - stall=0, kill=1: hold_buf dropped; IF/ID ← NOP (bubble+1); pc, addr_q ← tgt → FETCH.
- DRAIN: completes the stale request, then discards its data.
  - Every stall=0 cycle: IF/ID ← NOP, bubble+1.
  - kill=1 (stall=0): pc ← tgt, stay DRAIN.
  - ready=1: addr_q ← pc (or tgt if kill=1 the same cycle) → FETCH.
  - stall=1: IF/ID holds, no count; ready still completes the drain.
- Arithmetic: all 16-bit modulo. PC+1 of 16'hFFFF is 16'h0000. Counters wrap at 16'hFFFF → 0.

## Timing
- Reset (async, immediate): state=FETCH, pc=addr_q=RESET_PC, hold_buf=0, instruction=PC=NextPC=0, counters=0, imem_req=0.
- First request on the first cycle with reset low.
- Zero-wait memory: word requested in cycle n is on IF/ID outputs in cycle n+1; one instruction per cycle.
- Each memory wait cycle adds exactly one bubble.
- Taken redirect (kill in cycle k, ready=1): target requested in cycle k+1, on IF/ID in cycle k+2; exactly one bubble.
- Redirect with the request outstanding: bubbles continue until the stale ready, then normal fetch from the target.
- Reset mid-DRAIN or mid-HOLD: returns to FETCH at RESET_PC; the pending response is not tracked.

## Structure
- Shared package `if_pkg`:
  - state encodings S_FETCH=2'd0, S_HOLD=2'd1, S_DRAIN=2'd2;
  - PCSrc encodings PC_SEQ, PC_BR, PC_JMP, PC_FOR;
  - NOP word.
- Target select: reuse the existing `mux_4` with LENGTH=16. No new sub-module.

## Test plan
- Zero-wait memory, imem_data = address, 5 cycles → IF/ID shows PC 0,1,2,3,4 with NextPC 1..5; num_fetched=5, num_bubbles=0.
- ready low 2 cycles at addr 3 → two NOPs, imem_addr stays 3, then instruction from 3; num_bubbles=2.
- kill with PCSrc=01, Branch_TA=16'h0040, ready=1 → one NOP, then PC=16'h0040, NextPC=16'h0041.
- kill with PCSrc=10 while ready=0 at addr 7 → imem_addr stays 7 until ready; that word is never delivered; next IF/ID is Jump_TA.
- stall=1 at the same cycle ready=1 returns 16'hABCD from addr 9, held 3 cycles → IF/ID unchanged, imem_req=0 in HOLD; on release IF/ID = {ABCD, 9, 10}.
- pc=16'hFFFF fetch → NextPC=16'h0000, next request addr 0.
- reset asserted mid-DRAIN → all outputs 0 and imem_req=0 immediately; after release the first request is RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// if_pkg: shared encodings and constants for the instruction-fetch stage.
//   - FSM state encodings (S_FETCH / S_HOLD / S_DRAIN)
//   - PCSrc redirect-select encodings
//   - reset PC and NOP bubble word
package if_pkg;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] NOP      = 16'h0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } if_state_e;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10,
    PC_FOR = 2'b11
  } pc_src_e;

endpackage

// File: rtl/mux_4.sv
// mux_4: generic 4:1 multiplexer shared across the datapath.
//   in0..in3 : LENGTH-bit data inputs
//   sel      : 2-bit select (0 -> in0 ... 3 -> in3)
//   out      : selected input
module mux_4 #(
  parameter int LENGTH = 16
) (
  input  logic [LENGTH-1:0] in0,
  input  logic [LENGTH-1:0] in1,
  input  logic [LENGTH-1:0] in2,
  input  logic [LENGTH-1:0] in3,
  input  logic [1:0]        sel,
  output logic [LENGTH-1:0] out
);

  always_comb begin
    out = in0;
    case (sel)
      2'd0: out = in0;
      2'd1: out = in1;
      2'd2: out = in2;
      2'd3: out = in3;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage of the 16-bit pipeline.
// Owns the PC, issues word requests to instruction memory over a
// req/ready handshake and loads the IF/ID register consumed by decode.
// Ports:
//   clk, reset                 : clock, async active-high reset
//   stall                      : hazard unit hold (beats kill)
//   kill, PCSrc                : decode redirect and its target select
//   Branch_TA, Jump_TA, For_TA : redirect targets
//   imem_req/addr/data/ready   : instruction memory handshake
//   instruction, PC, NextPC    : IF/ID register
//   num_fetched, num_bubbles   : delivered instruction / NOP counters
module if_stage
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        kill,
  input  logic [1:0]  PCSrc,
  input  logic [15:0] Branch_TA,
  input  logic [15:0] Jump_TA,
  input  logic [15:0] For_TA,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_ready,
  output logic [15:0] instruction,
  output logic [15:0] PC,
  output logic [15:0] NextPC,
  output logic [15:0] num_fetched,
  output logic [15:0] num_bubbles
);

  if_state_e   state;
  logic [15:0] pc;
  logic [15:0] addr_q;
  logic [15:0] hold_buf;
  logic [15:0] tgt;
  logic [15:0] addr_inc;

  assign addr_inc = addr_q + 16'd1;

  // PCSrc=00 resumes at the address after the instruction sitting in
  // decode, i.e. the IF/ID NextPC.
  mux_4 #(.LENGTH(16)) u_tgt_mux (
    .in0 (NextPC),
    .in1 (Branch_TA),
    .in2 (Jump_TA),
    .in3 (For_TA),
    .sel (PCSrc),
    .out (tgt)
  );

  // No request while the response is parked in hold_buf, and never while
  // reset is asserted.
  assign imem_req  = ~reset & (state != S_HOLD);
  assign imem_addr = addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      addr_q      <= RESET_PC;
      hold_buf    <= 16'h0000;
      instruction <= 16'h0000;
      PC          <= 16'h0000;
      NextPC      <= 16'h0000;
      num_fetched <= 16'h0000;
      num_bubbles <= 16'h0000;
    end else begin
      case (state)
        S_FETCH: begin
          if (stall) begin
            // Park a response that lands during a stall; stop requesting.
            if (imem_ready) begin
              hold_buf <= imem_data;
              state    <= S_HOLD;
            end
          end else if (kill) begin
            instruction <= NOP;
            PC          <= 16'h0000;
            NextPC      <= 16'h0000;
            num_bubbles <= num_bubbles + 16'd1;
            pc          <= tgt;
            if (imem_ready) addr_q <= tgt;
            else            state  <= S_DRAIN;  // stale request still in flight
          end else if (imem_ready) begin
            instruction <= imem_data;
            PC          <= addr_q;
            NextPC      <= addr_inc;
            pc          <= addr_inc;
            addr_q      <= addr_inc;
            num_fetched <= num_fetched + 16'd1;
          end else begin
            instruction <= NOP;
            PC          <= 16'h0000;
            NextPC      <= 16'h0000;
            num_bubbles <= num_bubbles + 16'd1;
          end
        end

        S_HOLD: begin
          if (!stall) begin
            state <= S_FETCH;
            if (kill) begin
              instruction <= NOP;
              PC          <= 16'h0000;
              NextPC      <= 16'h0000;
              num_bubbles <= num_bubbles + 16'd1;
              pc          <= tgt;
              addr_q      <= tgt;
            end else begin
              instruction <= hold_buf;
              PC          <= addr_q;
              NextPC      <= addr_inc;
              pc          <= addr_inc;
              addr_q      <= addr_inc;
              num_fetched <= num_fetched + 16'd1;
            end
          end
        end

        S_DRAIN: begin
          // Bubbles keep flowing until the stale response arrives; its data
          // is thrown away and fetch restarts from pc (or a fresh target).
          if (!stall) begin
            instruction <= NOP;
            PC          <= 16'h0000;
            NextPC      <= 16'h0000;
            num_bubbles <= num_bubbles + 16'd1;
            if (kill) pc <= tgt;
          end
          if (imem_ready) begin
            addr_q <= (!stall && kill) ? tgt : pc;
            state  <= S_FETCH;
          end
        end

        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed + random stimulus for if_stage, checked against a
// transaction-level reference model of the fetch stage.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        kill = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [15:0] Branch_TA = 16'h0, Jump_TA = 16'h0, For_TA = 16'h0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_ready = 1'b0;
  logic [15:0] instruction, PC, NextPC, num_fetched, num_bubbles;

  int total = 0;
  int bad   = 0;

  // Memory image overridable per address for directed checks.
  logic [15:0] special_addr = 16'hFFFF;
  logic [15:0] special_data = 16'h0000;
  bit          special_en = 1'b0;

  function automatic logic [15:0] memf(input logic [15:0] a);
    if (special_en && a == special_addr) return special_data;
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  assign imem_data = memf(imem_addr);

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .kill(kill), .PCSrc(PCSrc),
    .Branch_TA(Branch_TA), .Jump_TA(Jump_TA), .For_TA(For_TA),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .imem_ready(imem_ready), .instruction(instruction), .PC(PC),
    .NextPC(NextPC), .num_fetched(num_fetched), .num_bubbles(num_bubbles)
  );

  // Reference model: a fetch address, plus "a word is parked" and
  // "a squashed request is still outstanding" flags.
  logic [15:0] m_pc, m_addr, m_buf, m_instr, m_PC, m_next, m_f, m_b;
  bit          m_parked, m_stale;

  function automatic bit m_req();
    return !reset && !m_parked;
  endfunction

  task automatic model_reset();
    m_pc = 16'h0; m_addr = 16'h0; m_buf = 16'h0;
    m_instr = 16'h0; m_PC = 16'h0; m_next = 16'h0; m_f = 16'h0; m_b = 16'h0;
    m_parked = 0; m_stale = 0;
  endtask

  task automatic bubble();
    m_instr = 16'h0; m_PC = 16'h0; m_next = 16'h0; m_b = m_b + 16'd1;
  endtask

  task automatic deliver(input logic [15:0] w);
    m_instr = w; m_PC = m_addr; m_next = m_addr + 16'd1;
    m_addr = m_addr + 16'd1; m_pc = m_addr; m_f = m_f + 16'd1;
  endtask

  task automatic model_clock(input bit st, input bit kl, input bit [1:0] sel,
                             input bit rdy);
    logic [15:0] t;
    t = (sel == 2'd0) ? m_next : (sel == 2'd1) ? Branch_TA :
        (sel == 2'd2) ? Jump_TA : For_TA;
    if (m_parked) begin
      if (!st) begin
        m_parked = 0;
        if (kl) begin bubble(); m_pc = t; m_addr = t; end
        else deliver(m_buf);
      end
    end else if (m_stale) begin
      if (!st) begin bubble(); if (kl) m_pc = t; end
      if (rdy) begin m_stale = 0; m_addr = m_pc; end
    end else if (st) begin
      if (rdy) begin m_buf = memf(m_addr); m_parked = 1; end
    end else if (kl) begin
      bubble(); m_pc = t;
      if (rdy) m_addr = t; else m_stale = 1;
    end else if (rdy) deliver(memf(m_addr));
    else bubble();
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_regs();
    chk("instruction", instruction, m_instr);
    chk("PC", PC, m_PC);
    chk("NextPC", NextPC, m_next);
    chk("num_fetched", num_fetched, m_f);
    chk("num_bubbles", num_bubbles, m_b);
  endtask

  // One clock: drive at negedge, check handshake outputs, clock, check IF/ID.
  task automatic step(input bit r, input bit st, input bit kl,
                      input bit [1:0] sel, input bit rdy);
    @(negedge clk);
    reset = r; stall = st; kill = kl; PCSrc = sel; imem_ready = rdy;
    if (r) model_reset();
    #1;
    chk("imem_req", {15'h0, imem_req}, {15'h0, m_req()});
    if (m_req()) chk("imem_addr", imem_addr, m_addr);
    if (r) check_regs();  // async reset must already be visible
    @(posedge clk);
    if (!r) model_clock(st, kl, sel, rdy);
    #1;
    check_regs();
  endtask

  initial begin
    model_reset();
    step(1, 0, 0, 0, 1);
    // Zero-wait streaming: PC 0..4, NextPC 1..5.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    chk("stream_fetched", num_fetched, 16'd5);
    chk("stream_last_pc", PC, 16'd4);
    // Two wait states then completion.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("wait_bubbles", num_bubbles, 16'd2);
    // Taken branch with ready=1: one bubble then 0x0040.
    Branch_TA = 16'h0040;
    step(0, 0, 1, 2'b01, 1);
    step(0, 0, 0, 0, 1);
    chk("branch_pc", PC, 16'h0040);
    chk("branch_next", NextPC, 16'h0041);
    // Jump while request outstanding: drain then Jump_TA.
    Jump_TA = 16'h1230;
    step(0, 0, 1, 2'b10, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("jump_pc", PC, 16'h1230);
    // Stall with response in hand: parked 3 cycles then delivered.
    special_en = 1; special_addr = 16'h1231; special_data = 16'hABCD;
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("hold_instr", instruction, 16'hABCD);
    chk("hold_next", NextPC, 16'h1232);
    special_en = 0;
    // Wrap at 16'hFFFF.
    For_TA = 16'hFFFF;
    step(0, 0, 1, 2'b11, 1);
    step(0, 0, 0, 0, 1);
    chk("wrap_next", NextPC, 16'h0000);
    step(0, 0, 0, 0, 1);
    chk("wrap_pc", PC, 16'h0000);
    // Reset mid-DRAIN.
    step(0, 0, 1, 2'b01, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("post_reset_pc", PC, 16'h0000);
    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      Branch_TA = $urandom;
      Jump_TA   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      For_TA    = $urandom;
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 6) == 0),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 7));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
